// File: rtl/tdm_pkg.sv
// Shared definitions for the tdm_demux4 receive path: FSM state encoding,
// slot count and slot index width.
package tdm_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  localparam logic ST_HUNT = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for tdm_demux4: 2-bit wrap counter that advances on
// accepted beats and loads 1 on a sync beat (the sync beat itself is slot 0).
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load1,
  output logic [SLOT_W-1:0] cnt
);

  // Sync load wins over increment; increment wraps 3 -> 0 by width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SLOT_W'(1);
    end else if (en) begin
      cnt <= cnt + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM demultiplexer. Slots 0..3 are collected into shadow
// registers and committed atomically to O1..O4 on the slot-3 beat, with a
// one-cycle frame_valid pulse. frame_sync on a valid beat marks slot 0.
// Optional build macro TDM_DEMUX_SYNC_ERR_EN adds sync_err (pulse per
// misaligned sync) and sync_err_cnt (saturating 8-bit count).
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [WIDTH-1:0]  O1,
  output logic [WIDTH-1:0]  O2,
  output logic [WIDTH-1:0]  O3,
  output logic [WIDTH-1:0]  O4,
  output logic              frame_valid,
  output logic              locked,
  output logic [SLOT_W-1:0] slot
`ifdef TDM_DEMUX_SYNC_ERR_EN
  ,
  output logic              sync_err,
  output logic [7:0]        sync_err_cnt
`endif
);

  logic             state;
  logic [WIDTH-1:0] sh0_p0;
  logic [WIDTH-1:0] sh1_p0;
  logic [WIDTH-1:0] sh2_p0;

  logic sync_beat;
  logic lock_beat;
  logic misalign;
  logic commit;

  assign sync_beat = din_valid && frame_sync;
  assign lock_beat = din_valid && (state == ST_LOCK);
  // A sync landing anywhere but slot 0 while locked restarts the frame.
  assign misalign  = sync_beat && (state == ST_LOCK) && (slot != '0);
  // Slot 3 completes a frame only if it is not itself a (misaligned) sync.
  assign commit    = lock_beat && !frame_sync && (slot == LAST_SLOT);
  assign locked    = (state == ST_LOCK);

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lock_beat),
    .load1 (sync_beat),
    .cnt   (slot)
  );

  // HUNT leaves on the first sync beat; only reset returns to HUNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HUNT;
    end else if (sync_beat) begin
      state <= ST_LOCK;
    end
  end

  // Stage p0: capture slot words 0..2; slot 3 goes straight to O4 at commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0_p0 <= '0;
      sh1_p0 <= '0;
      sh2_p0 <= '0;
    end else if (sync_beat) begin
      sh0_p0 <= din;
    end else if (lock_beat) begin
      case (slot)
        2'd0:    sh0_p0 <= din;
        2'd1:    sh1_p0 <= din;
        2'd2:    sh2_p0 <= din;
        default: ;
      endcase
    end
  end

  // Stage p1: atomic frame commit and its one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O1          <= '0;
      O2          <= '0;
      O3          <= '0;
      O4          <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= commit;
      if (commit) begin
        O1 <= sh0_p0;
        O2 <= sh1_p0;
        O3 <= sh2_p0;
        O4 <= din;
      end
    end
  end

`ifdef TDM_DEMUX_SYNC_ERR_EN
  // Misaligned-sync pulse and saturating event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err     <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      sync_err <= misalign;
      if (misalign && (sync_err_cnt != 8'hFF)) begin
        sync_err_cnt <= sync_err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with a frame-level reference model.
module tb_tdm_demux4;

  localparam int WIDTH = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             frame_sync = 1'b0;
  logic [WIDTH-1:0] O1, O2, O3, O4;
  logic             frame_valid;
  logic             locked;
  logic [1:0]       slot;
`ifdef TDM_DEMUX_SYNC_ERR_EN
  logic             sync_err;
  logic [7:0]       sync_err_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_valid    (din_valid),
    .frame_sync   (frame_sync),
    .O1           (O1),
    .O2           (O2),
    .O3           (O3),
    .O4           (O4),
    .frame_valid  (frame_valid),
    .locked       (locked),
    .slot         (slot)
`ifdef TDM_DEMUX_SYNC_ERR_EN
    ,
    .sync_err     (sync_err),
    .sync_err_cnt (sync_err_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words of the current frame collected in a queue; a
  // full queue of four is a frame, a sync restarts the queue.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_o [4];
  logic             m_fv;
  logic             m_aligned;
  logic             m_err;
  int               m_err_cnt;
  int               fv_pulses;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_o[i] = '0;
      m_fv = 1'b0;
      m_aligned = 1'b0;
      m_err = 1'b0;
      m_err_cnt = 0;
    end else begin
      m_fv = 1'b0;
      m_err = 1'b0;
      if (din_valid) begin
        if (frame_sync) begin
          if (m_aligned && q.size() != 0) begin
            m_err = 1'b1;
            if (m_err_cnt < 255) m_err_cnt++;
          end
          q.delete();
          q.push_back(din);
          m_aligned = 1'b1;
        end else if (m_aligned) begin
          q.push_back(din);
          if (q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_o[i] = q[i];
            m_fv = 1'b1;
            q.delete();
          end
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    chk("O1", 32'(O1), 32'(m_o[0]));
    chk("O2", 32'(O2), 32'(m_o[1]));
    chk("O3", 32'(O3), 32'(m_o[2]));
    chk("O4", 32'(O4), 32'(m_o[3]));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("locked", 32'(locked), 32'(m_aligned));
    chk("slot", 32'(slot), 32'(q.size()));
`ifdef TDM_DEMUX_SYNC_ERR_EN
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("sync_err_cnt", 32'(sync_err_cnt), 32'(m_err_cnt));
`endif
    if (frame_valid === 1'b1) fv_pulses++;
  end

  task automatic beat(input logic [WIDTH-1:0] d, input logic s);
    din = d;
    frame_sync = s;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Literal expectation on outputs, checked against both DUT and model.
  task automatic lit_outs(input string name, input logic [3:0] exp);
    chk({name, "_dut"}, 32'({O1, O2, O3, O4}), 32'(exp));
    chk({name, "_model"}, 32'({m_o[0], m_o[1], m_o[2], m_o[3]}), 32'(exp));
  endtask

  initial begin
    int fv0;
    fv_pulses = 0;
    // Reset / idle
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    lit_outs("reset_outs", 4'b0000);
    chk("reset_fv", 32'(frame_valid), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_slot", 32'(slot), 32'd0);

    // Basic frames
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0);
    lit_outs("basic1", 4'b0101);
    chk("basic1_fv", 32'(frame_valid), 32'd1);
    idle(1);
    chk("basic1_fv_drop", 32'(frame_valid), 32'd0);
    chk("basic1_slot_wrap", 32'(slot), 32'd0);
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    lit_outs("basic2", 4'b1010);
    chk("basic2_fv", 32'(frame_valid), 32'd1);
    idle(2);

    // Gapped frame
    fv0 = fv_pulses;
    beat(1'b0, 1'b1); idle(2);
    chk("gap_slot1", 32'(slot), 32'd1);
    beat(1'b1, 1'b0); idle(2);
    chk("gap_slot2", 32'(slot), 32'd2);
    lit_outs("gap_hold", 4'b1010);
    beat(1'b0, 1'b0); idle(2);
    beat(1'b1, 1'b0);
    chk("gap_fv", 32'(frame_valid), 32'd1);
    idle(3);
    lit_outs("gap_frame", 4'b0101);
    chk("gap_single_fv", 32'(fv_pulses - fv0), 32'd1);

    // HUNT discard
    pulse_reset();
    beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    chk("hunt_locked", 32'(locked), 32'd0);
    chk("hunt_slot", 32'(slot), 32'd0);
    beat(1'b0, 1'b1);
    chk("hunt_lock_rise", 32'(locked), 32'd1);
    beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    lit_outs("hunt_frame", 4'b0110);
    idle(1);

    // Misalignment
    fv0 = fv_pulses;
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    chk("mis_slot", 32'(slot), 32'd1);
    chk("mis_locked", 32'(locked), 32'd1);
    beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0);
    lit_outs("mis_frame", 4'b0001);
    idle(1);
    chk("mis_one_commit", 32'(fv_pulses - fv0), 32'd1);
`ifdef TDM_DEMUX_SYNC_ERR_EN
    chk("mis_err_cnt", 32'(sync_err_cnt), 32'd1);
`endif
    // Sync on slot 3 is misaligned: no commit
    fv0 = fv_pulses;
    beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b1);
    idle(1);
    chk("slot3_sync_no_commit", 32'(fv_pulses - fv0), 32'd0);
    lit_outs("slot3_sync_hold", 4'b0001);
    chk("slot3_sync_slot", 32'(slot), 32'd1);

    // Reset mid-frame
    pulse_reset();
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    lit_outs("midrst_clear", 4'b0000);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_slot", 32'(slot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    lit_outs("midrst_frame", 4'b0100);
    chk("midrst_fv", 32'(frame_valid), 32'd1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive side of the 4:1 channel multiplexing path: takes a time-division-multiplexed stream, one channel word per valid beat, and distributes it back onto four parallel channel outputs.
- Slot order matches the select encoding of the mux side: slot 0 → O1, slot 1 → O2, slot 2 → O3, slot 3 → O4.
- Frame alignment comes from a frame_sync marker on slot 0. Outputs update atomically once per complete frame.

Parameters:
- WIDTH, 1, bit width of each channel word (din and O1..O4).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  TDM channel word.
- din_valid  input  1  din carries a slot word this cycle.
- frame_sync  input  1  qualified by din_valid; marks the current beat as slot 0.
- O1  output  WIDTH  channel 1 word (slot 0) of the last complete frame.
- O2  output  WIDTH  channel 2 word (slot 1).
- O3  output  WIDTH  channel 3 word (slot 2).
- O4  output  WIDTH  channel 4 word (slot 3).
- frame_valid  output  1  one-cycle pulse: O1..O4 were just updated.
- locked  output  1  high while the state machine is in LOCK.
- slot  output  2  index of the next expected slot.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-low, on rst_n. While rst_n is low: O1..O4 = 0, frame_valid = 0, locked = 0, slot = 0, state = HUNT, shadow registers = 0.
- States:
  - HUNT: beats without frame_sync are discarded. A beat with din_valid && frame_sync stores din in shadow[0], sets slot = 1 and moves to LOCK.
  - LOCK: each din_valid beat stores din in shadow[slot] and increments slot modulo 4 (3 wraps to 0).
- Frame commit: on the edge that accepts slot 3, O1..O3 load shadow[0..2], O4 loads din directly, and frame_valid is high for exactly the following cycle. Latency from the slot-3 beat to the outputs is one clock.
- Outputs hold their values between commits. frame_valid is 0 on every cycle that does not follow a commit.
- din_valid low: no state change, slot holds; gaps of any length are allowed.
- frame_sync without din_valid is ignored.
- frame_sync with din_valid at slot 0 in LOCK: normal slot-0 capture.
- Misaligned sync (frame_sync with din_valid while slot ≠ 0 in LOCK):
  - the partial frame is discarded and no commit occurs;
  - the beat is captured as slot 0, slot becomes 1, and the state stays LOCK.
- A frame_sync arriving on the slot-3 beat is misaligned: no commit.
- Reset asserted mid-frame: the partial frame is lost and the block returns to HUNT immediately (asynchronous).
- locked = 1 exactly in LOCK. slot shows 0 in HUNT.

Optional Feature:
- Macro TDM_DEMUX_SYNC_ERR_EN.
- Defined:
  - adds output port sync_err (1 bit, reset 0);
  - sync_err pulses high for one cycle after every misaligned frame_sync;
  - adds output sync_err_cnt (8 bits, reset 0), which saturates at 255 and does not wrap.
- Undefined: neither port exists, and misaligned syncs realign silently. Core behaviour is identical in both builds.

Decomposition:
- Shared package/header tdm_pkg holds:
  - state encoding constants ST_HUNT = 1'b0, ST_LOCK = 1'b1;
  - SLOTS = 4;
  - slot index width = 2.
- Natural sub-module: tdm_slot_counter, a 2-bit wrap counter with enable (din_valid) and synchronous load-to-1 (sync beat) used by tdm_demux4. Capture, commit and state logic remain in the top.

Test Plan:
- Reset/idle: hold rst_n = 0 for 3 cycles, then release with din_valid = 0 → O1..O4 = 0, frame_valid = 0, locked = 0, slot = 0.
- Basic frame, WIDTH = 1: sync+0, 1, 0, 1 on consecutive beats → next cycle O1=0, O2=1, O3=0, O4=1 and a one-cycle frame_valid. Then sync+1, 0, 1, 0 → O1=1, O2=0, O3=1, O4=0.
- Gapped input: same frame with din_valid low for 2 cycles between each beat → identical outputs and a single frame_valid; slot holds during gaps.
- HUNT discard: beats 1, 1 without sync, then sync+0, 1, 1, 0 → commit shows 0, 1, 1, 0; locked rises on the sync beat.
- Misalignment, with TDM_DEMUX_SYNC_ERR_EN: sync+1, 1, then sync+0, 0, 0, 1 → no commit for the partial frame, commit shows 0, 0, 0, 1, sync_err pulses once and sync_err_cnt = 1.
- Reset mid-frame: sync+1, 1, then pulse rst_n low, then sync+0, 1, 0, 0 → O1..O4 cleared at reset; the next commit shows 0, 1, 0, 0.
